alu_exec_lane: RTL and testbench

- One execution lane downstream of the unified issue queue. It accepts one issued µop per cycle, computes the ALU result or the load/store address, and presents a completion packet to writeback/ROB.
- Two-stage pipeline with valid/ready backpressure: S1 operand latch, S2 result register.
- fu_ready_out drives the queue's per-lane FU-ready input.
- Three instances, LANE_ID 0..2, exist in the core.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/alu_exec_lane_if.sv | 46 ++++
 rtl/alu_exec_core.sv | 30 +++
 rtl/alu_exec_lane.sv | 151 +++++++++++++++
 tb/tb_alu_exec_lane.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: micro-op type codes, default tag widths and op-class helpers.
// Used by the issue queue, the ALU execution lanes and writeback.
package core_pkg;

    localparam int unsigned RobWDef  = 16;
    localparam int unsigned PregWDef = 6;

    typedef enum logic [3:0] {
        OpNone = 4'd0,
        OpAdd  = 4'd1,
        OpAddi = 4'd2,
        OpLui  = 4'd3,
        OpOri  = 4'd4,
        OpXor  = 4'd5,
        OpSrai = 4'd6,
        OpLb   = 4'd7,
        OpLw   = 4'd8,
        OpSb   = 4'd9,
        OpSw   = 4'd10
    } optype_e;

    typedef struct packed {
        logic [31:0] result;
        logic        we;
        logic        is_mem;
        logic        is_store;
        logic        mem_byte;
        logic [31:0] store_data;
    } exec_res_t;

    function automatic logic is_alu_op(logic [3:0] op);
        return op inside {OpAdd, OpAddi, OpLui, OpOri, OpXor, OpSrai};
    endfunction

    function automatic logic is_mem_op(logic [3:0] op);
        return op inside {OpLb, OpLw, OpSb, OpSw};
    endfunction

    function automatic logic is_store_op(logic [3:0] op);
        return op inside {OpSb, OpSw};
    endfunction

    function automatic logic is_byte_op(logic [3:0] op);
        return op inside {OpLb, OpSb};
    endfunction

    function automatic logic is_legal_op(logic [3:0] op);
        return is_alu_op(op) | is_mem_op(op);
    endfunction

endpackage

// File: rtl/alu_exec_lane_if.sv
// Issue-side and writeback-side handshake bundle of one ALU execution lane.
// master = issue queue / writeback environment, slave = the lane.
interface alu_exec_lane_if
    import core_pkg::*;
#(
    parameter int unsigned ROB_W  = RobWDef,
    parameter int unsigned PREG_W = PregWDef
);
    logic              issue_valid;
    logic              fu_ready_out;
    logic [31:0]       issue_pc;
    logic [3:0]        issue_optype;
    logic [31:0]       issue_src1;
    logic [31:0]       issue_src2;
    logic [31:0]       issue_imm;
    logic [PREG_W-1:0] issue_dest;
    logic [ROB_W-1:0]  issue_rob;

    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_pc;
    logic [ROB_W-1:0]  wb_rob;
    logic [PREG_W-1:0] wb_dest;
    logic [31:0]       wb_result;
    logic              wb_we;
    logic              wb_is_mem;
    logic              wb_is_store;
    logic              wb_mem_byte;
    logic [31:0]       wb_store_data;
    logic [1:0]        wb_alu_num;

    modport master (
        output issue_valid, issue_pc, issue_optype, issue_src1, issue_src2, issue_imm,
               issue_dest, issue_rob, wb_ready,
        input  fu_ready_out, wb_valid, wb_pc, wb_rob, wb_dest, wb_result, wb_we, wb_is_mem,
               wb_is_store, wb_mem_byte, wb_store_data, wb_alu_num
    );

    modport slave (
        input  issue_valid, issue_pc, issue_optype, issue_src1, issue_src2, issue_imm,
               issue_dest, issue_rob, wb_ready,
        output fu_ready_out, wb_valid, wb_pc, wb_rob, wb_dest, wb_result, wb_we, wb_is_mem,
               wb_is_store, wb_mem_byte, wb_store_data, wb_alu_num
    );

endinterface

// File: rtl/alu_exec_core.sv
// Combinational ALU / address-generation datapath placed between the S1 and S2 registers.
module alu_exec_core
    import core_pkg::*;
(
    input  logic [3:0]  optype_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [31:0] imm_i,
    output exec_res_t   res_o
);

    always_comb begin
        res_o = '0;
        case (optype_i)
            OpAdd:                        res_o.result = src1_i + src2_i;
            OpAddi, OpLb, OpLw, OpSb, OpSw: res_o.result = src1_i + imm_i;
            OpLui:                        res_o.result = imm_i;
            OpOri:                        res_o.result = src1_i | imm_i;
            OpXor:                        res_o.result = src1_i ^ src2_i;
            OpSrai:                       res_o.result = $unsigned($signed(src1_i) >>> imm_i[4:0]);
            default:                      res_o.result = '0;
        endcase
        res_o.we         = is_alu_op(optype_i);
        res_o.is_mem     = is_mem_op(optype_i);
        res_o.is_store   = is_store_op(optype_i);
        res_o.mem_byte   = is_byte_op(optype_i);
        res_o.store_data = is_store_op(optype_i) ? src2_i : '0;
    end

endmodule

// File: rtl/alu_exec_lane.sv
// Two-stage ALU execution lane (S1 operand latch, S2 result register) with valid/ready flow.
// Optional performance counters are enabled by defining ALU_PERF_CNT_EN.
module alu_exec_lane
    import core_pkg::*;
#(
    parameter int unsigned LANE_ID = 0,
    parameter int unsigned ROB_W   = RobWDef,
    parameter int unsigned PREG_W  = PregWDef
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    alu_exec_lane_if.slave bus
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]    perf_issued,
    output logic [31:0]    perf_stall,
    output logic [15:0]    perf_illegal
`endif
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [3:0]        op;
        logic [31:0]       src1;
        logic [31:0]       src2;
        logic [31:0]       imm;
        logic [PREG_W-1:0] dest;
        logic [ROB_W-1:0]  rob;
    } s1_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [PREG_W-1:0] dest;
        logic [ROB_W-1:0]  rob;
        exec_res_t         res;
    } s2_t;

    logic      s1_valid_q, s1_valid_d;
    logic      s2_valid_q, s2_valid_d;
    s1_t       s1_q, s1_d;
    s2_t       s2_q, s2_d;
    logic      s1_adv, s2_adv, accept, issue_legal;
    exec_res_t exec_res;

    // wb_ready reaches fu_ready_out combinationally so a full pipe still streams at 1/cycle
    assign s2_adv           = ~s2_valid_q | bus.wb_ready;
    assign s1_adv           = ~s1_valid_q | s2_adv;
    assign bus.fu_ready_out = s1_adv;
    assign accept           = bus.issue_valid & s1_adv;
    assign issue_legal      = is_legal_op(bus.issue_optype);

    alu_exec_core u_core (
        .optype_i (s1_q.op),
        .src1_i   (s1_q.src1),
        .src2_i   (s1_q.src2),
        .imm_i    (s1_q.imm),
        .res_o    (exec_res)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        // Illegal op-codes are consumed at the handshake but leave S1 empty
        if (s1_adv) begin
            s1_valid_d = accept & issue_legal;
        end
        if (accept) begin
            s1_d.pc   = bus.issue_pc;
            s1_d.op   = bus.issue_optype;
            s1_d.src1 = bus.issue_src1;
            s1_d.src2 = bus.issue_src2;
            s1_d.imm  = bus.issue_imm;
            s1_d.dest = bus.issue_dest;
            s1_d.rob  = bus.issue_rob;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            s2_d.pc   = s1_q.pc;
            s2_d.dest = s1_q.dest;
            s2_d.rob  = s1_q.rob;
            s2_d.res  = exec_res;
        end
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign bus.wb_valid      = s2_valid_q;
    assign bus.wb_pc         = s2_q.pc;
    assign bus.wb_rob        = s2_q.rob;
    assign bus.wb_dest       = s2_q.dest;
    assign bus.wb_result     = s2_q.res.result;
    assign bus.wb_we         = s2_q.res.we;
    assign bus.wb_is_mem     = s2_q.res.is_mem;
    assign bus.wb_is_store   = s2_q.res.is_store;
    assign bus.wb_mem_byte   = s2_q.res.mem_byte;
    assign bus.wb_store_data = s2_q.res.store_data;
    assign bus.wb_alu_num    = 2'(LANE_ID);

`ifdef ALU_PERF_CNT_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stall_q, stall_d;
    logic [15:0] illegal_q, illegal_d;

    always_comb begin
        issued_d  = issued_q;
        stall_d   = stall_q;
        illegal_d = illegal_q;
        if (accept && issue_legal)         issued_d  = issued_q + 32'd1;
        if (accept && !issue_legal)        illegal_d = illegal_q + 16'd1;
        if (s2_valid_q && !bus.wb_ready)   stall_d   = stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q  <= '0;
            stall_q   <= '0;
            illegal_q <= '0;
        end else begin
            issued_q  <= issued_d;
            stall_q   <= stall_d;
            illegal_q <= illegal_d;
        end
    end

    assign perf_issued  = issued_q;
    assign perf_stall   = stall_q;
    assign perf_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_exec_lane.sv
// Self-checking bench for alu_exec_lane: directed vector table, hand-written stall/flush/reset
// sequences and a randomized phase checked against a queue-based reference model.
module tb_alu_exec_lane;
    import core_pkg::*;

    localparam int unsigned LaneId = 2;
    localparam int unsigned RobW   = 16;
    localparam int unsigned PregW  = 6;

    typedef struct packed {
        logic [31:0]      pc;
        logic [RobW-1:0]  rob;
        logic [PregW-1:0] dest;
        logic [31:0]      result;
        logic             we;
        logic             is_mem;
        logic             is_store;
        logic             mem_byte;
        logic [31:0]      store_data;
    } pkt_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] imm;
        logic [31:0] res;
        logic [3:0]  flags;  // {we, is_mem, is_store, mem_byte}
        logic [31:0] sd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    alu_exec_lane_if #(.ROB_W(RobW), .PREG_W(PregW)) bus ();

`ifdef ALU_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
    logic [15:0] perf_illegal;
`endif

    alu_exec_lane #(.LANE_ID(LaneId), .ROB_W(RobW), .PREG_W(PregW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef ALU_PERF_CNT_EN
        ,
        .perf_issued  (perf_issued),
        .perf_stall   (perf_stall),
        .perf_illegal (perf_illegal)
`endif
    );

    int          n_checks = 0;
    int          n_fail = 0;
    pkt_t        exp_q[$];
    logic [15:0] obs_q[$];
    logic        hold_v = 1'b0;
    pkt_t        hold_p;
    logic        acc_seen = 1'b0;
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: result and flags straight from the op-code rules
    function automatic pkt_t ref_pkt(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                     logic [31:0] imm, logic [31:0] pc, logic [RobW-1:0] rob,
                                     logic [PregW-1:0] dest);
        pkt_t        r;
        logic [63:0] ext;
        r      = '0;
        r.pc   = pc;
        r.rob  = rob;
        r.dest = dest;
        case (op)
            4'd1: r.result = a + b;
            4'd2: r.result = a + imm;
            4'd3: r.result = imm;
            4'd4: r.result = a | imm;
            4'd5: r.result = a ^ b;
            4'd6: begin
                ext      = {{32{a[31]}}, a};
                ext      = ext >> imm[4:0];
                r.result = ext[31:0];
            end
            default: r.result = a + imm;
        endcase
        r.we         = (op >= 4'd1) && (op <= 4'd6);
        r.is_mem     = (op >= 4'd7) && (op <= 4'd10);
        r.is_store   = (op == 4'd9) || (op == 4'd10);
        r.mem_byte   = (op == 4'd7) || (op == 4'd9);
        r.store_data = r.is_store ? b : 32'd0;
        return r;
    endfunction

    function automatic pkt_t dut_pkt();
        pkt_t r;
        r.pc         = bus.wb_pc;
        r.rob        = bus.wb_rob;
        r.dest       = bus.wb_dest;
        r.result     = bus.wb_result;
        r.we         = bus.wb_we;
        r.is_mem     = bus.wb_is_mem;
        r.is_store   = bus.wb_is_store;
        r.mem_byte   = bus.wb_mem_byte;
        r.store_data = bus.wb_store_data;
        return r;
    endfunction

    // Scoreboard step, run at every falling edge while inputs are stable
    task automatic mon_step();
        logic exp_rdy;
        pkt_t a;
        acc_seen = bus.issue_valid && bus.fu_ready_out;
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
            return;
        end
        // At most two legal ops can be in flight; a full lane only moves if writeback takes one
        exp_rdy = (exp_q.size() < 2) || bus.wb_ready;
        chk("fu_ready", bus.fu_ready_out, exp_rdy);
        a = dut_pkt();
        if (hold_v) begin
            chk("hold_valid", bus.wb_valid, 1);
            chk("hold_pkt", a, hold_p);
        end
        if (bus.wb_valid) begin
            if (exp_q.size() == 0) chk("wb_spurious", bus.wb_valid, 0);
            else                   chk("wb_pkt", a, exp_q[0]);
        end
        if (flush) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (bus.wb_valid && bus.wb_ready && exp_q.size() > 0) begin
                obs_q.push_back(bus.wb_rob);
                void'(exp_q.pop_front());
            end
            hold_v = bus.wb_valid && !bus.wb_ready;
            hold_p = a;
            if (bus.issue_valid && exp_rdy && bus.issue_optype >= 4'd1 && bus.issue_optype <= 4'd10)
                exp_q.push_back(ref_pkt(bus.issue_optype, bus.issue_src1, bus.issue_src2,
                                        bus.issue_imm, bus.issue_pc, bus.issue_rob,
                                        bus.issue_dest));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input logic [RobW-1:0] rob, input logic [PregW-1:0] dest);
        bus.issue_optype = op;
        bus.issue_src1   = s1;
        bus.issue_src2   = s2;
        bus.issue_imm    = imm;
        bus.issue_pc     = pc;
        bus.issue_rob    = rob;
        bus.issue_dest   = dest;
        bus.issue_valid  = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (acc_seen) break;
        end
        if (!acc_seen) chk("accept_timeout", acc_seen, 1);
        bus.issue_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] imm, input logic [RobW-1:0] rob);
        present(op, s1, s2, imm, 32'h8000_0000 | 32'(rob), rob, 6'(rob));
        wait_accept();
    endtask

    initial begin
        vecs[0]  = '{4'd2,  32'd5,         32'd0,         32'hFFFF_FFFD, 32'd2,         4'b1000, 32'd0};
        vecs[1]  = '{4'd6,  32'h8000_0000, 32'd0,         32'd4,         32'hF800_0000, 4'b1000, 32'd0};
        vecs[2]  = '{4'd10, 32'h100,       32'hDEAD_BEEF, 32'd8,         32'h108,       4'b0110, 32'hDEAD_BEEF};
        vecs[3]  = '{4'd1,  32'd7,         32'd8,         32'd0,         32'd15,        4'b1000, 32'd0};
        vecs[4]  = '{4'd1,  32'hFFFF_FFFF, 32'd2,         32'd0,         32'd1,         4'b1000, 32'd0};
        vecs[5]  = '{4'd3,  32'hAAAA_AAAA, 32'd0,         32'h1234_5000, 32'h1234_5000, 4'b1000, 32'd0};
        vecs[6]  = '{4'd4,  32'hF0,        32'd0,         32'h0F,        32'hFF,        4'b1000, 32'd0};
        vecs[7]  = '{4'd5,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0,         32'hF00F_F00F, 4'b1000, 32'd0};
        vecs[8]  = '{4'd6,  32'h7FFF_FFF0, 32'd0,         32'h24,        32'h07FF_FFFF, 4'b1000, 32'd0};
        vecs[9]  = '{4'd7,  32'h1000,      32'h55,        32'hFFFF_FFFF, 32'hFFF,       4'b0101, 32'd0};
        vecs[10] = '{4'd8,  32'h2000,      32'd0,         32'd4,         32'h2004,      4'b0100, 32'd0};
        vecs[11] = '{4'd9,  32'h10,        32'hAB,        32'd1,         32'h11,        4'b0111, 32'hAB};

        bus.issue_valid = 1'b0;
        bus.wb_ready    = 1'b1;
        present(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0, 6'd0);
        bus.issue_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_pkt", dut_pkt(), 0);
        chk("rst_alu_num", bus.wb_alu_num, LaneId);
        chk("rst_fu_ready", bus.fu_ready_out, 1);
        rst = 1'b0;
        cyc();

        // Directed vectors: two-cycle latency and result/flag decode
        for (int i = 0; i < 12; i++) begin
            present(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].imm, 32'h1000 + 32'(4 * i),
                    16'(16'h100 + i), 6'(i));
            cyc();
            bus.issue_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), bus.wb_valid, 0);
            cyc();
            chk($sformatf("vec%0d_valid", i), bus.wb_valid, 1);
            chk($sformatf("vec%0d_result", i), bus.wb_result, vecs[i].res);
            chk($sformatf("vec%0d_flags", i),
                {bus.wb_we, bus.wb_is_mem, bus.wb_is_store, bus.wb_mem_byte}, vecs[i].flags);
            chk($sformatf("vec%0d_sdata", i), bus.wb_store_data, vecs[i].sd);
            chk($sformatf("vec%0d_tags", i), {bus.wb_pc, bus.wb_rob, bus.wb_dest, bus.wb_alu_num},
                {32'h1000 + 32'(4 * i), 16'(16'h100 + i), 6'(i), 2'(LaneId)});
        end
        cyc();

        // Illegal op-code: consumed, never completes
        send(4'd0, 32'd1, 32'd2, 32'd3, 16'h0AA);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("illegal_no_wb", bus.wb_valid, 0);
        end
`ifdef ALU_PERF_CNT_EN
        chk("perf_illegal", perf_illegal, 1);
        chk("perf_issued", perf_issued, 12);
        chk("perf_stall", perf_stall, 0);
`endif

        // Four ADDs with writeback stalled for three cycles after the first completion
        obs_q.delete();
        bus.wb_ready = 1'b1;
        send(4'd1, 32'd1, 32'd1, 32'd0, 16'h200);
        send(4'd1, 32'd2, 32'd2, 32'd0, 16'h201);
        chk("stream_first_valid", bus.wb_valid, 1);
        chk("stream_first_rob", bus.wb_rob, 16'h200);
        bus.wb_ready = 1'b0;
        present(4'd1, 32'd3, 32'd3, 32'd0, 32'h8000_0202, 16'h202, 6'd2);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_valid", bus.wb_valid, 1);
            chk("stall_rob", bus.wb_rob, 16'h200);
            chk("stall_result", bus.wb_result, 32'd2);
            chk("stall_fu_ready", bus.fu_ready_out, 0);
        end
        bus.wb_ready = 1'b1;
        wait_accept();
        send(4'd1, 32'd4, 32'd4, 32'd0, 16'h203);
        repeat (4) cyc();
        chk("stream_count", obs_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_q.size()) chk($sformatf("stream_tag%0d", k), obs_q[k], 16'(16'h200 + k));
        end

        // Flush with both stages full and a new issue presented
        obs_q.delete();
        bus.wb_ready = 1'b0;
        send(4'd1, 32'd5, 32'd5, 32'd0, 16'h300);
        send(4'd1, 32'd6, 32'd6, 32'd0, 16'h301);
        present(4'd1, 32'd7, 32'd7, 32'd0, 32'h8000_0302, 16'h302, 6'd2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        bus.issue_valid = 1'b0;
        chk("flush_wb_valid", bus.wb_valid, 0);
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("post_flush_idle", bus.wb_valid, 0);
        end
        chk("flush_no_old_tags", obs_q.size(), 0);

        // Reset while an op sits in S1
        send(4'd1, 32'd8, 32'd8, 32'd0, 16'h400);
        rst = 1'b1;
        #1;
        chk("midrst_wb_valid", bus.wb_valid, 0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("midrst_lost", bus.wb_valid, 0);
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            present(($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 10)),
                    $urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom()),
                    6'($urandom()));
            bus.issue_valid = ($urandom_range(0, 9) < 7);
            bus.wb_ready    = ($urandom_range(0, 9) < 7);
            flush           = ($urandom_range(0, 99) < 3);
            cyc();
        end
        flush = 1'b0;
        bus.issue_valid = 1'b0;
        bus.wb_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_wb_valid", bus.wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
